// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle between the UART receive FIFO and its producer/consumer.
// almost_full exists only when UART_RX_FIFO_AFULL_EN is defined.
interface uart_rx_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic [7:0]          rx_data;
  logic                rx_done;
  logic                rd_en;
  logic                ovf_clr;
  logic [7:0]          rd_data;
  logic                empty;
  logic                full;
  logic                overflow;
  logic [DEPTH_LOG2:0] count;
`ifdef UART_RX_FIFO_AFULL_EN
  logic                almost_full;
`endif

  modport master (
    output rx_data, rx_done, rd_en, ovf_clr,
    input  rd_data, empty, full, overflow, count
`ifdef UART_RX_FIFO_AFULL_EN
    , input almost_full
`endif
  );

  modport slave (
    input  rx_data, rx_done, rd_en, ovf_clr,
    output rd_data, empty, full, overflow, count
`ifdef UART_RX_FIFO_AFULL_EN
    , output almost_full
`endif
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Circular FWFT byte buffer behind the UART receiver with sticky overflow.
// Optional registered almost_full flag enabled by UART_RX_FIFO_AFULL_EN.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2  = 4,
  parameter int AFULL_LEVEL = 12
) (
  input logic          clk,
  input logic          rst,
  uart_rx_fifo_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   cnt_t;

  localparam ptr_t PTR_ONE  = ptr_t'(1);
  localparam cnt_t CNT_ONE  = cnt_t'(1);
  localparam cnt_t CNT_FULL = cnt_t'(DEPTH);

  logic [7:0] mem_q [DEPTH];
  ptr_t       wr_ptr_q, wr_ptr_d;
  ptr_t       rd_ptr_q, rd_ptr_d;
  cnt_t       count_q,  count_d;
  logic       overflow_q, overflow_d;
  logic       empty, full, push_ok, pop_ok, drop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_FULL);

  // A pop in the same cycle frees the slot a push into a full buffer needs.
  assign pop_ok  = bus.rd_en && !empty;
  assign push_ok = bus.rx_done && (!full || pop_ok);
  assign drop    = bus.rx_done && !push_ok;

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    if (drop)             overflow_d = 1'b1;
    else if (bus.ovf_clr) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: storage is deliberately left out of reset; empty gates rd_data so stale contents never leak.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= bus.rx_data;
  end

  assign bus.rd_data  = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign bus.empty    = empty;
  assign bus.full     = full;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;

`ifdef UART_RX_FIFO_AFULL_EN
  localparam cnt_t AFULL_CNT = cnt_t'(AFULL_LEVEL);
  logic afull_q;

  // Computed from count_d so the flag changes on the same edge as count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) afull_q <= 1'b0;
    else     afull_q <= (count_d >= AFULL_CNT);
  end

  assign bus.almost_full = afull_q;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: constant vectors, corner sequences and
// random traffic compared against a queue-based model of the buffer.
module tb_uart_rx_fifo;
  localparam int DEPTH_LOG2  = 4;
  localparam int DEPTH       = 1 << DEPTH_LOG2;
  localparam int AFULL_LEVEL = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

  uart_rx_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mq[$];
  bit         m_ovf;
  int         n_checks = 0;
  int         n_errors = 0;

  typedef struct {
    bit         push;
    logic [7:0] d;
    bit         pop;
    bit         clr;
    int         e_count;
    logic [7:0] e_rd;
    bit         e_empty;
    bit         e_full;
    bit         e_ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, " count"},    32'(bus.count),    32'(mq.size()));
    check({tag, " empty"},    32'(bus.empty),    32'(mq.size() == 0));
    check({tag, " full"},     32'(bus.full),     32'(mq.size() == DEPTH));
    check({tag, " overflow"}, 32'(bus.overflow), 32'(m_ovf));
    check({tag, " rd_data"},  32'(bus.rd_data),  (mq.size() > 0) ? 32'(mq[0]) : 32'h0);
`ifdef UART_RX_FIFO_AFULL_EN
    check({tag, " almost_full"}, 32'(bus.almost_full), 32'(mq.size() >= AFULL_LEVEL));
`endif
  endtask

  // One clock: drive inputs, advance the model at the edge, check 1 time unit later.
  task automatic cycle(input bit push, input logic [7:0] d, input bit pop, input bit clr,
                       input string tag);
    int size_now;
    bit pop_ok;
    bit accept;
    bus.rx_done = push;
    bus.rx_data = d;
    bus.rd_en   = pop;
    bus.ovf_clr = clr;
    @(posedge clk);
    size_now = mq.size();
    pop_ok   = pop && (size_now > 0);
    accept   = push && ((size_now < DEPTH) || pop_ok);
    if (pop_ok) void'(mq.pop_front());
    if (accept) mq.push_back(d);
    if (push && !accept) m_ovf = 1'b1;
    else if (clr)        m_ovf = 1'b0;
    #1;
    bus.rx_done = 1'b0;
    bus.rd_en   = 1'b0;
    bus.ovf_clr = 1'b0;
    check_model(tag);
  endtask

  initial begin
    vecs[0] = '{1'b1, 8'h41, 1'b0, 1'b0, 1, 8'h41, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'h42, 1'b0, 1'b0, 2, 8'h41, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 8'h43, 1'b0, 1'b0, 3, 8'h41, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 8'h42, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 8'h43, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 8'h55, 1'b1, 1'b0, 1, 8'h55, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b1, 1'b0, 1'b0};

    rst         = 1'b1;
    bus.rx_done = 1'b0;
    bus.rx_data = 8'h00;
    bus.rd_en   = 1'b0;
    bus.ovf_clr = 1'b0;
    m_ovf       = 1'b0;
    #23 rst = 1'b0;
    check("reset count",    32'(bus.count),    32'h0);
    check("reset empty",    32'(bus.empty),    32'h1);
    check("reset full",     32'(bus.full),     32'h0);
    check("reset overflow", 32'(bus.overflow), 32'h0);
    check("reset rd_data",  32'(bus.rd_data),  32'h0);
`ifdef UART_RX_FIFO_AFULL_EN
    check("reset almost_full", 32'(bus.almost_full), 32'h0);
`endif
    cycle(1'b0, 8'h00, 1'b0, 1'b0, "idle");

    for (int i = 0; i < 9; i++) begin
      cycle(vecs[i].push, vecs[i].d, vecs[i].pop, vecs[i].clr, $sformatf("vec%0d model", i));
      check($sformatf("vec%0d count", i),    32'(bus.count),    32'(vecs[i].e_count));
      check($sformatf("vec%0d rd_data", i),  32'(bus.rd_data),  32'(vecs[i].e_rd));
      check($sformatf("vec%0d empty", i),    32'(bus.empty),    32'(vecs[i].e_empty));
      check($sformatf("vec%0d full", i),     32'(bus.full),     32'(vecs[i].e_full));
      check($sformatf("vec%0d overflow", i), 32'(bus.overflow), 32'(vecs[i].e_ovf));
    end

    // Fill past capacity: 17th byte dropped, drain order, then clear overflow.
    for (int i = 0; i <= DEPTH; i++) begin
      cycle(1'b1, 8'(i), 1'b0, 1'b0, "fill");
      if (i == DEPTH - 1) begin
        check("fill16 full",  32'(bus.full),     32'h1);
        check("fill16 count", 32'(bus.count),    32'(DEPTH));
        check("fill16 ovf",   32'(bus.overflow), 32'h0);
      end
    end
    check("fill17 ovf",   32'(bus.overflow), 32'h1);
    check("fill17 count", 32'(bus.count),    32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("drain%0d rd_data", i), 32'(bus.rd_data), 32'(i));
      cycle(1'b0, 8'h00, 1'b1, 1'b0, "drain");
    end
    check("drained empty", 32'(bus.empty),    32'h1);
    check("drained ovf",   32'(bus.overflow), 32'h1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, "ovf_clr");
    check("ovf cleared", 32'(bus.overflow), 32'h0);

    // Dropped push together with ovf_clr keeps overflow; push+pop on full is accepted.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, "refill");
    cycle(1'b1, 8'hEE, 1'b0, 1'b1, "drop+clr");
    check("set wins ovf", 32'(bus.overflow), 32'h1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, "clr");
    check("clr ovf", 32'(bus.overflow), 32'h0);
    cycle(1'b1, 8'hAA, 1'b1, 1'b0, "full push+pop");
    check("full push+pop count", 32'(bus.count),    32'(DEPTH));
    check("full push+pop ovf",   32'(bus.overflow), 32'h0);
    check("full push+pop head",  32'(bus.rd_data),  32'h61);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) check("last byte", 32'(bus.rd_data), 32'hAA);
      cycle(1'b0, 8'h00, 1'b1, 1'b0, "drain2");
    end

    // Asynchronous reset mid-stream, checked before the next clock edge.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, "pre-rst");
    check("pre-rst count", 32'(bus.count), 32'h5);
    #2 rst = 1'b1;
    #1;
    mq.delete();
    m_ovf = 1'b0;
    check("async rst count",   32'(bus.count),   32'h0);
    check("async rst empty",   32'(bus.empty),   32'h1);
    check("async rst rd_data", 32'(bus.rd_data), 32'h0);
    @(posedge clk);
    #2 rst = 1'b0;
    check_model("post-rst");

    // Two rounds of 10 push/10 pop cross the 15->0 pointer wrap.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h10 * r + 8'h20 + i), 1'b0, 1'b0, "wrap push");
      for (int i = 0; i < 10; i++) begin
        check($sformatf("wrap r%0d i%0d", r, i), 32'(bus.rd_data), 32'(8'h10 * r + 8'h20 + i));
        cycle(1'b0, 8'h00, 1'b1, 1'b0, "wrap pop");
      end
    end

`ifdef UART_RX_FIFO_AFULL_EN
    for (int i = 0; i < AFULL_LEVEL - 1; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, "af fill");
    check("afull at 11", 32'(bus.almost_full), 32'h0);
    cycle(1'b1, 8'h77, 1'b0, 1'b0, "af 12");
    check("afull at 12", 32'(bus.almost_full), 32'h1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "af 11");
    check("afull back 11", 32'(bus.almost_full), 32'h0);
    for (int i = 0; i < AFULL_LEVEL - 1; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "af drain");
`endif

    // Random traffic in phases biased toward filling, balanced and draining.
    for (int i = 0; i < 3000; i++) begin
      int push_pct;
      int pop_pct;
      push_pct = (i % 600 < 200) ? 85 : (i % 600 < 400) ? 50 : 20;
      pop_pct  = 100 - push_pct;
      cycle($urandom_range(99, 0) < push_pct, 8'($urandom), $urandom_range(99, 0) < pop_pct,
            $urandom_range(99, 0) < 4, "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side byte buffer that sits directly downstream of the UART receiver. Each one-cycle receive-done strobe pushes the accompanying 8-bit byte into a circular buffer. The consumer (command decoder / stopwatch-DHT control logic) drains the buffer through a first-word-fall-through read port. Full, empty and overflow conditions are reported so no received byte is lost silently.

Parameters:
- DEPTH_LOG2, 4, log2 of buffer depth (default depth 16 bytes); legal range 2..8.
- AFULL_LEVEL, 12, occupancy at or above which almost_full asserts; used only with the optional feature; legal range 1..DEPTH.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- rx_data  input  8  received byte from the UART receiver; valid only in the cycle rx_done=1
- rx_done  input  1  one-cycle push strobe from the UART receiver
- rd_en  input  1  pop request from the consumer
- rd_data  output  8  head byte (FWFT); forced 8'h00 while empty
- empty  output  1  buffer holds 0 bytes
- full  output  1  buffer holds DEPTH bytes
- count  output  DEPTH_LOG2+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky; a push was dropped
- ovf_clr  input  1  synchronous clear of overflow
- almost_full  output  1  present only with UART_RX_FIFO_AFULL_EN

Behaviour:
- Reset: clk with rst asynchronous, active-high. Asserting rst at any time, including mid-burst, immediately sets wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, overflow=0, rd_data=8'h00, almost_full=0. Memory contents are not reset and are don't-care.
- Storage: DEPTH=2^DEPTH_LOG2 entries of 8 bits, with DEPTH_LOG2-bit read and write pointers that wrap modulo DEPTH (DEPTH-1 -> 0).
- Push (rx_done=1):
  - Not full: mem[wr_ptr] <= rx_data, wr_ptr++.
  - Full: byte is dropped, pointers are unchanged, and overflow is set on the next edge.
- Pop (rd_en=1 and empty=0): rd_ptr++. A pop while empty is ignored and has no error flag.
- rd_data: combinational mem[rd_ptr] whenever empty=0. After a pop edge, rd_data shows the next byte in the same cycle the pointer updates. Zero read latency; write-to-read latency is 1 cycle (a byte pushed at edge N is visible on rd_data after edge N when the buffer was empty).
- Simultaneous push and pop:
  - Neither empty nor full: both occur and count is unchanged.
  - Full: pop frees a slot, so the push is accepted (no overflow) and count stays DEPTH.
  - Empty: pop is ignored, push is accepted, and count becomes 1.
- count / flags: count is registered; +1 on accepted push only, -1 on accepted pop only. empty = (count==0); full = (count==DEPTH). Both are derived from the registered count, with no glitch between edges.
- overflow: set on a dropped push and held until ovf_clr=1 at an edge. If a dropped push and ovf_clr occur in the same cycle, set wins and overflow stays 1.
- No internal state machine beyond the pointer/count registers. Every register updates only on posedge clk or async rst.

Optional Feature:
- Macro UART_RX_FIFO_AFULL_EN.
- Defined: port almost_full exists; almost_full = (count >= AFULL_LEVEL), registered together with count. Its reset value is 0. It is used for software flow-control (XOFF) generation.
- Undefined: almost_full port and its logic are absent, AFULL_LEVEL is unused, and all other behaviour is identical.

Test Plan:
- Reset then idle -> empty=1, full=0, count=0, overflow=0, rd_data=8'h00.
- Push 8'h41, 8'h42, 8'h43 on separate strobes, then rd_en three cycles -> rd_data 41, 42, 43 in order; count 3 then 2, 1, 0; empty=1 at the end.
- Push 17 bytes 8'h00..8'h10 at DEPTH=16 -> full=1 after the 16th and count=16; the 17th is dropped and overflow=1. Draining yields 00..0F. ovf_clr -> overflow=0.
- With full, assert rx_done=1 (8'hAA) and rd_en=1 together -> no overflow, count stays 16. After a full drain, the last byte read is 8'hAA.
- Pointer wrap: push 10 and pop 10, then push 10 and pop 10 with distinct values -> data order is preserved across the wrap boundary 15->0.
- Assert rst with count=5 mid-stream -> count=0, empty=1, rd_data=8'h00 immediately. Under UART_RX_FIFO_AFULL_EN with AFULL_LEVEL=12: almost_full=1 exactly when count reaches 12 and drops back at 11.
